// File: rtl/axi_txn_limiter.sv
// ---------------------------------------------------------------------------
// axi_txn_limiter_pkg
//   AXI channel payload and request/response bundle types used by the
//   limiter. The limiter itself only looks at valid/ready, r.last, r.resp
//   and b.resp; every other field is forwarded untouched.
// ---------------------------------------------------------------------------
package axi_txn_limiter_pkg;

  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
  } axi_ax_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic                 last;
  } axi_w_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
  } axi_r_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [1:0]         resp;
  } axi_b_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    axi_b_t  b;
    logic    r_valid;
    axi_r_t  r;
  } axi_rsp_t;

endpackage

// ---------------------------------------------------------------------------
// axi_txn_limiter
//   Sits between the cache subsystem AXI master port and the interconnect.
//   Caps outstanding AR and AW bursts, drains the port on request and flags
//   error / protocol-violation responses. Payloads pass through with zero
//   added latency; only ar/aw valid (down) and ar/aw ready (up) are gated.
//
// Ports
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   axi_req_i        request from cache subsystem
//   axi_resp_o       response to cache subsystem
//   axi_req_o        request to interconnect
//   axi_resp_i       response from interconnect
//   drain_i          level: block new AR/AW and wait for the port to empty
//   drained_o        port empty and blocked
//   busy_o           anything outstanding or an AR/AW held valid downstream
//   resp_err_o       pulse on R(last)/B handshake with SLVERR/DECERR
//   proto_err_o      sticky: response handshake while its count was zero
//   dbg_state_o      FSM state (debug)
//   dbg_rd_cnt_o     outstanding read bursts (debug)
//   dbg_wr_cnt_o     outstanding write bursts (debug)
//
// Handshake semantics: a transfer happens on a channel in every cycle where
// its valid and ready are both high at the rising clock edge. Once valid is
// presented downstream it stays high with stable payload until ready.
// ---------------------------------------------------------------------------
module axi_txn_limiter #(
  parameter type         axi_req_t   = axi_txn_limiter_pkg::axi_req_t,
  parameter type         axi_rsp_t   = axi_txn_limiter_pkg::axi_rsp_t,
  parameter int unsigned MaxReadTxn  = 8,
  parameter int unsigned MaxWriteTxn = 4,
  parameter int unsigned CntWidth    =
    $clog2(((MaxReadTxn > MaxWriteTxn) ? MaxReadTxn : MaxWriteTxn) + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  axi_req_t            axi_req_i,
  output axi_rsp_t            axi_resp_o,
  output axi_req_t            axi_req_o,
  input  axi_rsp_t            axi_resp_i,
  input  logic                drain_i,
  output logic                drained_o,
  output logic                busy_o,
  output logic                resp_err_o,
  output logic                proto_err_o,
  output logic [1:0]          dbg_state_o,
  output logic [CntWidth-1:0] dbg_rd_cnt_o,
  output logic [CntWidth-1:0] dbg_wr_cnt_o
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_DRAIN   = 2'd1;
  localparam logic [1:0] ST_DRAINED = 2'd2;

  localparam logic [CntWidth-1:0] RdMax = CntWidth'(MaxReadTxn);
  localparam logic [CntWidth-1:0] WrMax = CntWidth'(MaxWriteTxn);
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  logic [1:0]          state_q, state_d;
  logic [CntWidth-1:0] rd_cnt_q, rd_cnt_d;
  logic [CntWidth-1:0] wr_cnt_q, wr_cnt_d;
  logic                ar_held_q, ar_held_d;
  logic                aw_held_q, aw_held_d;
  logic                proto_err_q, proto_err_d;

  logic ar_open, aw_open;
  logic ar_fwd, aw_fwd;
  logic rd_inc, rd_dec, wr_inc, wr_dec;
  logic rd_uflow, wr_uflow;

  // A held AR/AW must stay open regardless of drain or limit so the
  // downstream valid never drops before acceptance.
  always_comb begin
    ar_open = ar_held_q | ((state_q == ST_RUN) & (rd_cnt_q < RdMax));
    aw_open = aw_held_q | ((state_q == ST_RUN) & (wr_cnt_q < WrMax));
    ar_fwd  = axi_req_i.ar_valid & ar_open;
    aw_fwd  = axi_req_i.aw_valid & aw_open;
  end

  always_comb begin
    axi_req_o           = axi_req_i;
    axi_req_o.ar_valid  = ar_fwd;
    axi_req_o.aw_valid  = aw_fwd;
    axi_resp_o          = axi_resp_i;
    axi_resp_o.ar_ready = axi_resp_i.ar_ready & ar_open;
    axi_resp_o.aw_ready = axi_resp_i.aw_ready & aw_open;
  end

  always_comb begin
    rd_inc = ar_fwd & axi_resp_i.ar_ready;
    rd_dec = axi_resp_i.r_valid & axi_req_i.r_ready & axi_resp_i.r.last;
    wr_inc = aw_fwd & axi_resp_i.aw_ready;
    wr_dec = axi_resp_i.b_valid & axi_req_i.b_ready;
  end

  // Counters: simultaneous inc/dec cancel; a lone dec at zero is a
  // protocol violation and leaves the count at zero.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    rd_uflow = 1'b0;
    if (rd_inc && !rd_dec) begin
      rd_cnt_d = rd_cnt_q + CntOne;
    end else if (rd_dec && !rd_inc) begin
      if (rd_cnt_q == '0) rd_uflow = 1'b1;
      else                rd_cnt_d = rd_cnt_q - CntOne;
    end
  end

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    wr_uflow = 1'b0;
    if (wr_inc && !wr_dec) begin
      wr_cnt_d = wr_cnt_q + CntOne;
    end else if (wr_dec && !wr_inc) begin
      if (wr_cnt_q == '0) wr_uflow = 1'b1;
      else                wr_cnt_d = wr_cnt_q - CntOne;
    end
  end

  // Held = forwarded but not yet accepted.
  always_comb begin
    ar_held_d   = ar_fwd & ~axi_resp_i.ar_ready;
    aw_held_d   = aw_fwd & ~axi_resp_i.aw_ready;
    proto_err_d = proto_err_q | rd_uflow | wr_uflow;
  end

  // Drain completion looks at next-state counts so drained_o rises the
  // cycle after the final response handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (drain_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!drain_i) begin
          state_d = ST_RUN;
        end else if ((rd_cnt_d == '0) && (wr_cnt_d == '0) &&
                     !ar_held_d && !aw_held_d) begin
          state_d = ST_DRAINED;
        end
      end
      ST_DRAINED: begin
        if (!drain_i) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_RUN;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      ar_held_q   <= 1'b0;
      aw_held_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      ar_held_q   <= ar_held_d;
      aw_held_q   <= aw_held_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_comb begin
    drained_o    = (state_q == ST_DRAINED);
    busy_o       = (rd_cnt_q != '0) | (wr_cnt_q != '0) | ar_held_q | aw_held_q;
    resp_err_o   = (rd_dec & axi_resp_i.r.resp[1]) | (wr_dec & axi_resp_i.b.resp[1]);
    proto_err_o  = proto_err_q;
    dbg_state_o  = state_q;
    dbg_rd_cnt_o = rd_cnt_q;
    dbg_wr_cnt_o = wr_cnt_q;
  end

endmodule

// File: tb/tb_axi_txn_limiter.sv
// ---------------------------------------------------------------------------
// tb_axi_txn_limiter
//   Randomized traffic checked every cycle against a transaction-level
//   reference model (queues of outstanding bursts, a mode variable), plus
//   directed scenarios: limit, simultaneous inc/dec, valid stability under
//   drain, drain/resume, error pulses, asynchronous reset.
// ---------------------------------------------------------------------------
module tb_axi_txn_limiter;
  import axi_txn_limiter_pkg::*;

  localparam int MAX_RD = 8;
  localparam int MAX_WR = 4;
  localparam int M_RUN = 0, M_DRAIN = 1, M_DRAINED = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_req_t   req_i, req_o;
  axi_rsp_t   rsp_i, rsp_o;
  logic       drain;
  logic       drained, busy, resp_err, proto_err;
  logic [1:0] dbg_state;
  logic [3:0] dbg_rd_cnt, dbg_wr_cnt;

  axi_txn_limiter #(.MaxReadTxn(MAX_RD), .MaxWriteTxn(MAX_WR)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .axi_req_i   (req_i),
    .axi_resp_o  (rsp_o),
    .axi_req_o   (req_o),
    .axi_resp_i  (rsp_i),
    .drain_i     (drain),
    .drained_o   (drained),
    .busy_o      (busy),
    .resp_err_o  (resp_err),
    .proto_err_o (proto_err),
    .dbg_state_o (dbg_state),
    .dbg_rd_cnt_o(dbg_rd_cnt),
    .dbg_wr_cnt_o(dbg_wr_cnt)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [IdWidth-1:0] rd_q[$];   // outstanding read bursts (by id)
  logic [IdWidth-1:0] wr_q[$];   // outstanding write bursts (by id)
  bit  m_ar_pend, m_aw_pend;     // forwarded downstream, not yet accepted
  int  m_mode;
  bit  m_proto;
  bit  ar_fire, aw_fire, r_fire, b_fire;
  int  dut_ar_hs;
  int  n_total, n_bad;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    rd_q.delete();
    wr_q.delete();
    m_ar_pend = 0; m_aw_pend = 0; m_mode = M_RUN; m_proto = 0;
    ar_fire = 0; aw_fire = 0; r_fire = 0; b_fire = 0;
    dut_ar_hs = 0;
  endfunction

  // Compare every output against the model for the current inputs and
  // record which transfers the model says complete at the next edge.
  task automatic check_outputs();
    bit ar_ok, aw_ok, exp_err;
    ar_ok = m_ar_pend || (m_mode == M_RUN && rd_q.size() < MAX_RD);
    aw_ok = m_aw_pend || (m_mode == M_RUN && wr_q.size() < MAX_WR);
    ar_fire = req_i.ar_valid && ar_ok && rsp_i.ar_ready;
    aw_fire = req_i.aw_valid && aw_ok && rsp_i.aw_ready;
    r_fire  = rsp_i.r_valid && req_i.r_ready && rsp_i.r.last;
    b_fire  = rsp_i.b_valid && req_i.b_ready;
    exp_err = (r_fire && rsp_i.r.resp[1]) || (b_fire && rsp_i.b.resp[1]);
    if (req_o.ar_valid && rsp_i.ar_ready) dut_ar_hs++;
    check_eq("ar_valid_o", req_o.ar_valid, req_i.ar_valid && ar_ok);
    check_eq("ar_ready_o", rsp_o.ar_ready, rsp_i.ar_ready && ar_ok);
    check_eq("aw_valid_o", req_o.aw_valid, req_i.aw_valid && aw_ok);
    check_eq("aw_ready_o", rsp_o.aw_ready, rsp_i.aw_ready && aw_ok);
    check_eq("ar_addr", req_o.ar.addr, req_i.ar.addr);
    check_eq("aw_addr", req_o.aw.addr, req_i.aw.addr);
    check_eq("w_valid", req_o.w_valid, req_i.w_valid);
    check_eq("w_data", req_o.w.data, req_i.w.data);
    check_eq("w_ready", rsp_o.w_ready, rsp_i.w_ready);
    check_eq("r_data", rsp_o.r.data, rsp_i.r.data);
    check_eq("r_valid", rsp_o.r_valid, rsp_i.r_valid);
    check_eq("r_ready", req_o.r_ready, req_i.r_ready);
    check_eq("b_valid", rsp_o.b_valid, rsp_i.b_valid);
    check_eq("b_ready", req_o.b_ready, req_i.b_ready);
    check_eq("resp_err", resp_err, exp_err);
    check_eq("busy", busy, rd_q.size() != 0 || wr_q.size() != 0 || m_ar_pend || m_aw_pend);
    check_eq("drained", drained, m_mode == M_DRAINED);
    check_eq("proto_err", proto_err, m_proto);
    check_eq("rd_cnt", dbg_rd_cnt, rd_q.size());
    check_eq("wr_cnt", dbg_wr_cnt, wr_q.size());
  endtask

  function automatic void model_update();
    if (ar_fire) rd_q.push_back(req_i.ar.id);
    if (aw_fire) wr_q.push_back(req_i.aw.id);
    if (r_fire) begin
      if (rd_q.size() > 0) void'(rd_q.pop_front());
      else m_proto = 1;
    end
    if (b_fire) begin
      if (wr_q.size() > 0) void'(wr_q.pop_front());
      else m_proto = 1;
    end
    m_ar_pend = req_i.ar_valid && !rsp_i.ar_ready &&
                (m_ar_pend || (m_mode == M_RUN && rd_q.size() - (ar_fire ? 1 : 0) + (r_fire ? 1 : 0) < MAX_RD));
    m_aw_pend = req_i.aw_valid && !rsp_i.aw_ready &&
                (m_aw_pend || (m_mode == M_RUN && wr_q.size() - (aw_fire ? 1 : 0) + (b_fire ? 1 : 0) < MAX_WR));
    case (m_mode)
      M_RUN:     if (drain) m_mode = M_DRAIN;
      M_DRAIN:   if (!drain) m_mode = M_RUN;
                 else if (rd_q.size() == 0 && wr_q.size() == 0 && !m_ar_pend && !m_aw_pend)
                   m_mode = M_DRAINED;
      M_DRAINED: if (!drain) m_mode = M_RUN;
      default:   m_mode = M_RUN;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // One clock: check at negedge, advance model at posedge, return at +1.
  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    req_i = '0;
    rsp_i = '0;
    drain = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Upstream master keeps a request stable until its handshake; the
  // downstream slave only responds when something is outstanding.
  task automatic rand_inputs();
    if (!req_i.ar_valid || ar_fire) begin
      req_i.ar_valid = ($urandom_range(0, 99) < 60);
      req_i.ar.id    = IdWidth'($urandom);
      req_i.ar.addr  = $urandom;
      req_i.ar.len   = 8'($urandom);
    end
    if (!req_i.aw_valid || aw_fire) begin
      req_i.aw_valid = ($urandom_range(0, 99) < 50);
      req_i.aw.id    = IdWidth'($urandom);
      req_i.aw.addr  = $urandom;
      req_i.aw.len   = 8'($urandom);
    end
    rsp_i.ar_ready = ($urandom_range(0, 1) == 1);
    rsp_i.aw_ready = ($urandom_range(0, 1) == 1);
    req_i.w_valid  = ($urandom_range(0, 1) == 1);
    req_i.w.data   = {$urandom, $urandom};
    req_i.w.last   = ($urandom_range(0, 1) == 1);
    rsp_i.w_ready  = ($urandom_range(0, 1) == 1);
    rsp_i.r_valid  = (rd_q.size() > 0) && ($urandom_range(0, 99) < 60);
    rsp_i.r.last   = ($urandom_range(0, 99) < 60);
    rsp_i.r.resp   = 2'($urandom_range(0, 3));
    rsp_i.r.data   = {$urandom, $urandom};
    req_i.r_ready  = ($urandom_range(0, 3) != 0);
    rsp_i.b_valid  = (wr_q.size() > 0) && ($urandom_range(0, 99) < 50);
    rsp_i.b.resp   = 2'($urandom_range(0, 3));
    req_i.b_ready  = ($urandom_range(0, 3) != 0);
    if ($urandom_range(0, 24) == 0) drain = ~drain;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    n_total = 0;
    n_bad = 0;
    idle_inputs();
    model_reset();
    #1;
    check_eq("rst_drained", drained, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_proto", proto_err, 1'b0);
    check_eq("rst_rd_cnt", dbg_rd_cnt, 0);
    do_reset();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step();
    end

    // Limit: 8 accepted, then blocked; R last frees a slot one cycle later
    do_reset();
    req_i.ar_valid = 1'b1;
    rsp_i.ar_ready = 1'b1;
    repeat (12) step();
    check_eq("lim_acc", dut_ar_hs, 8);
    check_eq("lim_cnt", dbg_rd_cnt, 8);
    #1 check_eq("lim_blk", req_o.ar_valid, 1'b0);
    rsp_i.r_valid = 1'b1; req_i.r_ready = 1'b1; rsp_i.r.last = 1'b1;
    step();
    check_eq("lim_no_bypass", dut_ar_hs, 8);
    rsp_i.r_valid = 1'b0;
    step();
    check_eq("lim_ar9", dut_ar_hs, 9);
    check_eq("lim_cnt9", dbg_rd_cnt, 8);

    // Simultaneous AR accept and R last; non-last beats leave count alone
    req_i.ar_valid = 1'b0;
    rsp_i.r_valid = 1'b1;
    repeat (5) step();
    check_eq("sim_pre", dbg_rd_cnt, 3);
    req_i.ar_valid = 1'b1;
    step();
    check_eq("sim_cnt", dbg_rd_cnt, 3);
    check_eq("sim_hs", dut_ar_hs, 10);
    req_i.ar_valid = 1'b0;
    rsp_i.r.last = 1'b0;
    repeat (3) step();
    check_eq("sim_nonlast", dbg_rd_cnt, 3);
    rsp_i.r_valid = 1'b0;

    // Stability: held AR survives drain, next AR is blocked
    do_reset();
    req_i.ar_valid = 1'b1;
    req_i.ar.addr = 32'h1000;
    repeat (2) step();
    drain = 1'b1;
    repeat (3) step();
    #1 check_eq("stab_held", req_o.ar_valid, 1'b1);
    rsp_i.ar_ready = 1'b1;
    step();
    check_eq("stab_acc", dut_ar_hs, 1);
    req_i.ar.addr = 32'h2000;
    #1 check_eq("stab_blk", req_o.ar_valid, 1'b0);
    repeat (2) step();
    check_eq("stab_cnt", dbg_rd_cnt, 1);

    // Drain with 2 reads + 1 write outstanding, then resume
    do_reset();
    req_i.ar_valid = 1'b1; rsp_i.ar_ready = 1'b1;
    req_i.aw_valid = 1'b1; rsp_i.aw_ready = 1'b1;
    step();
    req_i.aw_valid = 1'b0;
    step();
    req_i.ar_valid = 1'b0;
    drain = 1'b1;
    step();
    check_eq("drn_rd", dbg_rd_cnt, 2);
    check_eq("drn_wr", dbg_wr_cnt, 1);
    rsp_i.r_valid = 1'b1; req_i.r_ready = 1'b1; rsp_i.r.last = 1'b1;
    repeat (2) step();
    rsp_i.r_valid = 1'b0;
    check_eq("drn_wait", drained, 1'b0);
    rsp_i.b_valid = 1'b1; req_i.b_ready = 1'b1;
    step();
    rsp_i.b_valid = 1'b0;
    check_eq("drn_rise", drained, 1'b1);
    step();
    drain = 1'b0;
    step();
    check_eq("drn_fall", drained, 1'b0);
    req_i.ar_valid = 1'b1;
    #1 check_eq("drn_resume", req_o.ar_valid, 1'b1);
    step();
    req_i.ar_valid = 1'b0;

    // Errors: SLVERR pulse, then B with nothing outstanding
    do_reset();
    req_i.aw_valid = 1'b1; rsp_i.aw_ready = 1'b1;
    step();
    req_i.aw_valid = 1'b0;
    rsp_i.b_valid = 1'b1; req_i.b_ready = 1'b1; rsp_i.b.resp = 2'b10;
    #1 check_eq("err_pulse", resp_err, 1'b1);
    step();
    rsp_i.b_valid = 1'b0;
    #1 check_eq("err_pulse_end", resp_err, 1'b0);
    rsp_i.b_valid = 1'b1; rsp_i.b.resp = 2'b00;
    step();
    rsp_i.b_valid = 1'b0;
    check_eq("proto_set", proto_err, 1'b1);
    check_eq("proto_wr0", dbg_wr_cnt, 0);
    repeat (2) step();
    check_eq("proto_sticky", proto_err, 1'b1);

    // Asynchronous reset mid-burst, between clock edges
    req_i.ar_valid = 1'b1; rsp_i.ar_ready = 1'b1;
    repeat (5) step();
    req_i.ar_valid = 1'b0;
    check_eq("ar_rd5", dbg_rd_cnt, 5);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar_rst_rd", dbg_rd_cnt, 0);
    check_eq("ar_rst_busy", busy, 1'b0);
    check_eq("ar_rst_proto", proto_err, 1'b0);
    check_eq("ar_rst_drained", drained, 1'b0);
    check_eq("ar_rst_err", resp_err, 1'b0);
    do_reset();
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
